// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//
// Bus responder for the ag6502 CPU bus. It answers CPU reads from a decoded
// memory map and stretches accesses with programmable wait states on RDY.
// The memory map has a reset vector pair, a small writable RAM window at the
// bottom of the address space, and a fill opcode everywhere else. It also
// counts opcode fetches and records every completed write in a small trace
// FIFO that the host drains.
//
// Ports:
//   CLK            in   1       single clock, rising edge
//   RESET          in   1       synchronous, active-high reset
//   AB             in   ADDR_W  CPU address bus
//   RDWR_          in   1       1 = read, 0 = write
//   DO             in   DATA_W  CPU write data
//   SYNC           in   1       opcode fetch cycle
//   DI             out  DATA_W  registered read data to the CPU
//   RDY            out  1       registered CPU ready
//   fetch_count    out  CNT_W   completed opcode fetches, saturating
//   trace_valid    out  1       trace FIFO head is valid
//   trace_addr     out  ADDR_W  trace FIFO head address
//   trace_data     out  DATA_W  trace FIFO head data
//   trace_ready    in   1       pop the trace FIFO head when trace_valid=1
//   trace_overflow out  1       sticky: a write was dropped on a full FIFO

module cpu_bus_responder #(
    parameter int                  ADDR_W      = 16,
    parameter int                  DATA_W      = 8,
    parameter int                  RAM_AW      = 8,
    parameter logic [2*DATA_W-1:0] RESET_VEC   = 16'hE000,
    parameter logic [ADDR_W-1:0]   VEC_ADDR    = 16'hFFFC,
    parameter logic [DATA_W-1:0]   FILL_OP     = 8'hEA,
    parameter int                  WAIT_STATES = 0,
    parameter int                  TRACE_DEPTH = 8,
    parameter int                  CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] AB,
    input  logic              RDWR_,
    input  logic [DATA_W-1:0] DO,
    input  logic              SYNC,
    output logic [DATA_W-1:0] DI,
    output logic              RDY,
    output logic [CNT_W-1:0]  fetch_count,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    input  logic              trace_ready,
    output logic              trace_overflow
);

    localparam int RAM_DEPTH = 1 << RAM_AW;
    localparam int PTR_W     = $clog2(TRACE_DEPTH);

    localparam logic [ADDR_W-1:0] VEC_ADDR_HI = VEC_ADDR + {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        WAIT_LOAD   = WAIT_STATES[3:0];
    localparam logic [PTR_W:0]    FULL_COUNT  = TRACE_DEPTH[PTR_W:0];

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [DATA_W-1:0] ram [RAM_DEPTH];

    logic [0:0]        state;
    logic [3:0]        wait_cnt;

    logic              completed;
    logic              is_vec_lo;
    logic              is_vec_hi;
    logic              in_ram;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic [DATA_W-1:0] read_data;

    logic [ADDR_W-1:0] fifo_addr [TRACE_DEPTH];
    logic [DATA_W-1:0] fifo_data [TRACE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              full;

    // An access completes on every cycle the CPU sees RDY high.
    assign completed = (state == ST_RUN);
    assign RDY       = completed;

    // Address decode; the RAM window is every address whose bits above
    // RAM_AW are all zero.
    assign is_vec_lo = (AB == VEC_ADDR);
    assign is_vec_hi = (AB == VEC_ADDR_HI);
    assign in_ram    = ((AB >> RAM_AW) == '0);
    assign ram_idx   = AB[RAM_AW-1:0];

    // The vector pair takes priority, so a vector overlapping the RAM window
    // stays read-only.
    assign ram_we = completed && !RDWR_ && in_ram && !is_vec_lo && !is_vec_hi && !RESET;

    // Read mux in priority order: vector low, vector high, RAM, fill opcode.
    always_comb begin
        read_data = FILL_OP;
        if (is_vec_lo) begin
            read_data = RESET_VEC[DATA_W-1:0];
        end else if (is_vec_hi) begin
            read_data = RESET_VEC[2*DATA_W-1:DATA_W];
        end else if (in_ram) begin
            read_data = ram[ram_idx];
        end
    end

    // RAM storage is not reset. A read of the address being written in the
    // same cycle returns the old contents, because DI samples before the write.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[ram_idx] <= DO;
        end
    end

    // DI follows the decode of the current address every cycle, whatever RDY
    // and RDWR_ are, so the CPU always sees the data one cycle after AB.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            DI <= '0;
        end else begin
            DI <= read_data;
        end
    end

    // Wait-state FSM: each completed access is followed by WAIT_STATES cycles
    // of RDY low. The counter is loaded with WAIT_STATES and the FSM returns
    // to RUN on the cycle the counter reads 1.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (WAIT_STATES > 0) begin
                        state    <= ST_STALL;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                default: begin
                    if (wait_cnt == 4'd1) begin
                        state <= ST_RUN;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // Opcode fetch counter; only completed fetches count, so a fetch held
    // across a stall is counted once. Saturates at all-ones.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_count <= '0;
        end else if (completed && SYNC && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 1'b1;
        end
    end

    // Trace FIFO handshake. A pop in the same cycle frees a slot, so a push
    // into a full FIFO is still accepted when the head is popped alongside.
    assign push_req = completed && !RDWR_;
    assign full     = (fifo_count == FULL_COUNT);
    assign pop      = trace_valid && trace_ready;
    assign push_ok  = push_req && (!full || pop);

    // Trace storage; the pointers wrap naturally because the depth is a
    // power of two.
    always_ff @(posedge CLK) begin
        if (push_ok && !RESET) begin
            fifo_addr[wr_ptr] <= AB;
            fifo_data[wr_ptr] <= DO;
        end
    end

    // Trace pointers, occupancy and the sticky overflow flag. Reset discards
    // any push pending in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !push_ok) begin
                trace_overflow <= 1'b1;
            end
        end
    end

    // First-word fall-through: the head entry is presented directly.
    assign trace_valid = (fifo_count != '0);
    assign trace_addr  = fifo_addr[rd_ptr];
    assign trace_data  = fifo_data[rd_ptr];

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder
//
// Bench for cpu_bus_responder with two wait states, a four-entry trace FIFO
// and a four-bit fetch counter. Directed accesses drive the CPU side. A
// behavioural model of the memory map, RDY timing, fetch count and trace
// queue is compared with the DUT every cycle. Literal expectations pin
// the key points of each scenario.

module tb_cpu_bus_responder;

    localparam int WAIT  = 2;
    localparam int DEPTH = 4;
    localparam int CNTW  = 4;
    localparam int FETCH_MAX = (1 << CNTW) - 1;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] AB;
    logic        RDWR_;
    logic [7:0]  DO;
    logic        SYNC;
    logic        trace_ready;
    logic [7:0]  DI;
    logic        RDY;
    logic [3:0]  fetch_count;
    logic        trace_valid;
    logic [15:0] trace_addr;
    logic [7:0]  trace_data;
    logic        trace_overflow;

    int checks = 0;
    int errors = 0;

    cpu_bus_responder #(
        .WAIT_STATES (WAIT),
        .TRACE_DEPTH (DEPTH),
        .CNT_W       (CNTW)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .AB             (AB),
        .RDWR_          (RDWR_),
        .DO             (DO),
        .SYNC           (SYNC),
        .DI             (DI),
        .RDY            (RDY),
        .fetch_count    (fetch_count),
        .trace_valid    (trace_valid),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_ready    (trace_ready),
        .trace_overflow (trace_overflow)
    );

    always #5 CLK = ~CLK;

    // Single comparison point shared by the model checker and literal checks.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: memory map, RDY stretch, fetch count, trace queue.
    logic [7:0]  m_mem [256];
    bit          m_known [256];
    logic [7:0]  m_di;
    bit          m_di_known;
    bit          m_rdy;
    int          m_stall;
    int          m_fetch;
    logic [23:0] m_q [$];
    bit          m_ovf;
    bit          m_live = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_known[i] = 1'b0;
        end
    end

    // Model update on every rising edge from the inputs present before it.
    always @(posedge CLK) begin
        bit done;
        bit push;
        bit pop;
        if (RESET) begin
            m_di       = 8'h00;
            m_di_known = 1'b1;
            m_rdy      = 1'b1;
            m_stall    = 0;
            m_fetch    = 0;
            m_q.delete();
            m_ovf      = 1'b0;
            m_live     = 1'b1;
        end else begin
            done = m_rdy;
            m_di_known = 1'b1;
            if (AB == 16'hFFFC) begin
                m_di = 8'h00;
            end else if (AB == 16'hFFFD) begin
                m_di = 8'hE0;
            end else if (AB < 16'd256) begin
                m_di       = m_mem[AB[7:0]];
                m_di_known = m_known[AB[7:0]];
            end else begin
                m_di = 8'hEA;
            end
            if (done && SYNC && m_fetch < FETCH_MAX) begin
                m_fetch = m_fetch + 1;
            end
            push = done && !RDWR_;
            pop  = (m_q.size() > 0) && trace_ready;
            if (push && AB < 16'd256) begin
                m_mem[AB[7:0]]   = DO;
                m_known[AB[7:0]] = 1'b1;
            end
            if (pop) begin
                void'(m_q.pop_front());
            end
            if (push) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({AB, DO});
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (done) begin
                m_stall = WAIT;
            end else if (m_stall > 0) begin
                m_stall = m_stall - 1;
            end
            m_rdy = (m_stall == 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_live) begin
            if (m_di_known) begin
                checkOutput("di", 32'(DI), 32'(m_di));
            end
            checkOutput("rdy", 32'(RDY), 32'(m_rdy));
            checkOutput("fetch_count", 32'(fetch_count), 32'(m_fetch));
            checkOutput("trace_valid", 32'(trace_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                checkOutput("trace_addr", 32'(trace_addr), 32'(m_q[0][23:8]));
                checkOutput("trace_data", 32'(trace_data), 32'(m_q[0][7:0]));
            end
            checkOutput("trace_overflow", 32'(trace_overflow), 32'(m_ovf));
        end
    end

    // Drive one access and hold it until the DUT completes it (RDY high at
    // the edge). Afterwards the bus idles as a read of the same address.
    task automatic applyStimulus(input logic [15:0] addr, input bit rd, input logic [7:0] data,
                                 input bit sync, input bit pop_at_end);
        bit done;
        AB    = addr;
        RDWR_ = rd;
        DO    = data;
        SYNC  = sync;
        done  = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge CLK);
            done = RDY;
            if (done && pop_at_end) begin
                trace_ready = 1'b1;
            end
            @(posedge CLK);
            #1;
            if (pop_at_end) begin
                trace_ready = 1'b0;
            end
        end
        if (!done) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL access_timeout: addr %0h never completed", addr);
        end
        RDWR_ = 1'b1;
        SYNC  = 1'b0;
    endtask

    task automatic doReset(input int cycles);
        RESET = 1'b1;
        repeat (cycles) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    logic [15:0] drain_addr [4];
    logic [7:0]  drain_data [4];

    initial begin
        AB          = 16'h0000;
        RDWR_       = 1'b1;
        DO          = 8'h00;
        SYNC        = 1'b0;
        trace_ready = 1'b0;
        RESET       = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        checkOutput("reset_di", 32'(DI), 32'h00);
        checkOutput("reset_rdy", 32'(RDY), 32'h1);
        checkOutput("reset_fetch", 32'(fetch_count), 32'h0);
        checkOutput("reset_valid", 32'(trace_valid), 32'h0);
        checkOutput("reset_ovf", 32'(trace_overflow), 32'h0);
        #1;

        $display("[TB] vector and fill reads");
        applyStimulus(16'hFFFC, 1'b1, 8'h00, 1'b0, 1'b0);
        #1 checkOutput("vec_lo", 32'(DI), 32'h00);
        applyStimulus(16'hFFFD, 1'b1, 8'h00, 1'b0, 1'b0);
        #1 checkOutput("vec_hi", 32'(DI), 32'hE0);
        applyStimulus(16'hE000, 1'b1, 8'h00, 1'b0, 1'b0);
        #1 checkOutput("fill", 32'(DI), 32'hEA);

        $display("[TB] RAM window and trace");
        applyStimulus(16'h0042, 1'b0, 8'h5A, 1'b0, 1'b0);
        applyStimulus(16'h0034, 1'b0, 8'h11, 1'b0, 1'b0);
        applyStimulus(16'h1234, 1'b0, 8'h77, 1'b0, 1'b0);
        applyStimulus(16'h0042, 1'b1, 8'h00, 1'b0, 1'b0);
        #1 checkOutput("ram_read", 32'(DI), 32'h5A);
        applyStimulus(16'h0034, 1'b1, 8'h00, 1'b0, 1'b0);
        #1 checkOutput("outside_write_ignored", 32'(DI), 32'h11);
        applyStimulus(16'h0042, 1'b0, 8'h99, 1'b0, 1'b0);
        #1 checkOutput("read_during_write_old", 32'(DI), 32'h5A);
        checkOutput("trace_head_addr", 32'(trace_addr), 32'h0042);
        checkOutput("trace_full_no_ovf", 32'(trace_overflow), 32'h0);
        applyStimulus(16'h0042, 1'b1, 8'h00, 1'b0, 1'b0);
        #1 checkOutput("ram_new_data", 32'(DI), 32'h99);

        $display("[TB] wait states");
        doReset(1);
        applyStimulus(16'h0100, 1'b1, 8'h00, 1'b1, 1'b0);
        SYNC = 1'b1;
        #1 checkOutput("stall_1", 32'(RDY), 32'h0);
        checkOutput("fetch_once", 32'(fetch_count), 32'h1);
        @(posedge CLK);
        #2 checkOutput("stall_2", 32'(RDY), 32'h0);
        @(posedge CLK);
        #2 checkOutput("stall_end", 32'(RDY), 32'h1);
        checkOutput("held_fetch_not_recounted", 32'(fetch_count), 32'h1);
        SYNC = 1'b0;
        #1;

        $display("[TB] fetch counter");
        doReset(1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(16'hE000 + 16'(i), 1'b1, 8'h00, 1'b1, 1'b0);
        end
        #1 checkOutput("fetch_10", 32'(fetch_count), 32'd10);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(16'hE010 + 16'(i), 1'b1, 8'h00, 1'b1, 1'b0);
        end
        #1 checkOutput("fetch_saturate", 32'(fetch_count), 32'hF);

        $display("[TB] trace FIFO boundaries");
        doReset(1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h0010 + 16'(i), 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0);
        end
        #1 checkOutput("overflow_set", 32'(trace_overflow), 32'h1);
        checkOutput("head_after_overflow", 32'(trace_addr), 32'h0010);
        applyStimulus(16'h0015, 1'b0, 8'hA5, 1'b0, 1'b1);
        #1 checkOutput("full_push_pop_head", 32'(trace_addr), 32'h0011);
        drain_addr[0] = 16'h0011; drain_data[0] = 8'hA1;
        drain_addr[1] = 16'h0012; drain_data[1] = 8'hA2;
        drain_addr[2] = 16'h0013; drain_data[2] = 8'hA3;
        drain_addr[3] = 16'h0015; drain_data[3] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_valid", 32'(trace_valid), 32'h1);
            checkOutput("drain_addr", 32'(trace_addr), 32'(drain_addr[i]));
            checkOutput("drain_data", 32'(trace_data), 32'(drain_data[i]));
            trace_ready = 1'b1;
            @(posedge CLK);
            #2;
            trace_ready = 1'b0;
        end
        checkOutput("drained_empty", 32'(trace_valid), 32'h0);
        checkOutput("overflow_sticky", 32'(trace_overflow), 32'h1);

        $display("[TB] reset during stall");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h0020 + 16'(i), 1'b0, 8'hB0 + 8'(i), 1'b1, 1'b0);
        end
        #1 checkOutput("pre_reset_stall", 32'(RDY), 32'h0);
        checkOutput("pre_reset_fetch", 32'(fetch_count), 32'h3);
        AB    = 16'h0023;
        RDWR_ = 1'b0;
        DO    = 8'hC3;
        RESET = 1'b1;
        @(posedge CLK);
        #2 checkOutput("post_reset_rdy", 32'(RDY), 32'h1);
        checkOutput("post_reset_valid", 32'(trace_valid), 32'h0);
        checkOutput("post_reset_ovf", 32'(trace_overflow), 32'h0);
        checkOutput("post_reset_fetch", 32'(fetch_count), 32'h0);
        @(posedge CLK);
        #2 checkOutput("reset_push_discarded", 32'(trace_valid), 32'h0);
        RESET = 1'b0;
        RDWR_ = 1'b1;
        repeat (4) @(posedge CLK);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
